ysyx_22050078_lsu: RTL and testbench
====================================

Name: ysyx_22050078_lsu

Overview:
- Load/store stage directly downstream of the execute unit.
- Takes the 64-bit execute result as the effective address (or as pass-through data for non-memory ops) and runs a single outstanding request on a req/gnt/rvalid data-memory port.
- Aligns and byte-masks store data; extracts and sign/zero-extends load data.
- Hands the write-back value to the next stage over a valid/ready handshake.

Parameters:
- CPU_WIDTH, 64, datapath and address width.
- OPT_WIDTH, 4, width of the load/store opcode.

Ports:
- i_clk  in  1  clock; all state updates on its rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  upstream op valid
- o_ready  out  1  stage can accept an op (high only in IDLE)
- i_exu_res  in  64  execute result: effective address, or pass-through data
- i_wdata  in  64  store data (rs2)
- i_lsopt  in  4  0=NONE 1=LB 2=LH 3=LW 4=LD 5=LBU 6=LHU 7=LWU 8=SB 9=SH 10=SW 11=SD; 12-15 treated as NONE
- o_valid  out  1  result valid to write-back
- i_ready  in  1  write-back accepts result
- o_rdata  out  64  write-back value
- o_mem_req  out  1  memory request
- i_mem_gnt  in  1  request accepted
- o_mem_addr  out  64  doubleword-aligned address ({addr[63:3],3'b0})
- o_mem_wen  out  1  request is a store
- o_mem_wdata  out  64  store data shifted to byte lane addr[2:0]
- o_mem_wmask  out  8  byte enables (stores); 0 for loads
- i_mem_rvalid  in  1  load data returned
- i_mem_rdata  in  64  load doubleword

Behaviour:
- FSM states: IDLE, REQ, RESP, DONE. Reset enters IDLE.
- Reset values: o_valid=0, o_mem_req=0, o_mem_wen=0, o_mem_wmask=0, o_rdata=0, o_mem_addr=0, o_mem_wdata=0.
- IDLE:
  - o_ready=1. A transfer occurs when i_valid&o_ready.
  - On transfer, capture opt, addr, wdata.
  - NONE: o_rdata<=i_exu_res, go DONE.
  - Load/store: go REQ.
- REQ:
  - o_mem_req=1 with address, wen, wdata and mask held stable until i_mem_gnt.
  - On gnt: a store goes DONE with o_rdata<=0; a load goes RESP.
  - req drops the cycle after gnt.
- RESP:
  - Wait for i_mem_rvalid. rvalid asserted in any other state is ignored.
  - On rvalid, select the byte lane by addr[2:0], extend (LB/LH/LW sign; LBU/LHU/LWU zero; LD full), register into o_rdata, go DONE.
- DONE:
  - o_valid=1 and o_rdata held until i_ready; then go IDLE.
  - No bypass: the next op is accepted the cycle after the handshake.
- Minimum latency, transfer to o_valid:
  - NONE: 1 cycle.
  - Store with same-cycle gnt: 2 cycles.
  - Load with gnt and rvalid each 1 cycle later: 3 cycles.
- Store mask: SB 1<<a, SH 3<<a, SW 0x0F<<a, SD 0xFF, where a=addr[2:0]; wdata shifted left by 8*a.
- Misalignment: an access is misaligned when addr is not a multiple of its size. Behaviour is defined under the optional feature. Without the feature, bytes that fall beyond the doubleword are dropped from the mask, or read as 0.
- i_rst asserted in any state returns to IDLE next cycle and drops req/valid. The memory side must tolerate an abandoned request.
- Upstream inputs are sampled only on transfer; changes while busy are ignored.

Optional Feature:
- Macro: YSYX_22050078_LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output o_misalign (1 bit, reset 0).
  - A misaligned load/store skips REQ and goes straight to DONE with o_rdata<=captured address and o_misalign=1.
  - o_misalign is valid only with o_valid and clears on the handshake.
  - No memory request is issued for that op.
- Undefined: port absent; misaligned accesses use the truncating behaviour above.

Test Plan:
- NONE, i_exu_res=0x1234, i_ready=1 -> o_valid one cycle after transfer, o_rdata=0x1234, o_mem_req never asserted.
- LB addr 0x8000_0003, i_mem_rdata=0x0000_0000_8000_0000, gnt after 2 cycles -> o_mem_addr=0x8000_0000, o_rdata=0xFFFF_FFFF_FFFF_FF80. LBU at the same address -> 0x80.
- SH addr 0x8000_0006, wdata=0xBEEF -> o_mem_wen=1, wmask=0xC0, wdata=0xBEEF_0000_0000_0000, req held until gnt, then o_valid with o_rdata=0.
- LW addr 0x10, rdata=0x7FFF_FFFF_8000_0001, i_ready low for 3 cycles -> o_rdata=0xFFFF_FFFF_8000_0001 held stable, o_ready=0 throughout.
- i_rst asserted while in RESP -> next cycle IDLE, o_ready=1, o_valid=0. A late rvalid is ignored.
- With the feature: LD addr 0x8000_0004 -> no req, o_valid next cycle, o_misalign=1, o_rdata=0x8000_0004.

Source files
------------

// File: rtl/ysyx_22050078_lsu.sv
// rtl/ysyx_22050078_lsu.sv - load/store stage with a single outstanding req/gnt/rvalid memory access
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_valid / o_ready        upstream handshake (o_ready high only in IDLE)
//   i_exu_res                effective address, or pass-through data for non-memory ops
//   i_wdata                  store data (rs2)
//   i_lsopt                  0=NONE 1=LB 2=LH 3=LW 4=LD 5=LBU 6=LHU 7=LWU 8=SB 9=SH 10=SW 11=SD, 12-15=NONE
//   o_valid / i_ready        write-back handshake, o_rdata is the write-back value
//   o_mem_*  / i_mem_*       data-memory port (req/gnt request phase, rvalid response phase)
//   o_misalign               only with YSYX_22050078_LSU_MISALIGN_TRAP_EN: misaligned access flagged with o_valid
//
// Optional feature macro: YSYX_22050078_LSU_MISALIGN_TRAP_EN
module ysyx_22050078_lsu #(
    parameter int CPU_WIDTH = 64,
    parameter int OPT_WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [CPU_WIDTH-1:0] i_exu_res,
    input  logic [CPU_WIDTH-1:0] i_wdata,
    input  logic [OPT_WIDTH-1:0] i_lsopt,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [CPU_WIDTH-1:0] o_rdata,
    output logic                 o_mem_req,
    input  logic                 i_mem_gnt,
    output logic [CPU_WIDTH-1:0] o_mem_addr,
    output logic                 o_mem_wen,
    output logic [CPU_WIDTH-1:0] o_mem_wdata,
    output logic [7:0]           o_mem_wmask,
    input  logic                 i_mem_rvalid,
    input  logic [CPU_WIDTH-1:0] i_mem_rdata
`ifdef YSYX_22050078_LSU_MISALIGN_TRAP_EN
    ,
    output logic                 o_misalign
`endif
);

    localparam logic [OPT_WIDTH-1:0] OP_LB  = 4'd1;
    localparam logic [OPT_WIDTH-1:0] OP_LH  = 4'd2;
    localparam logic [OPT_WIDTH-1:0] OP_LW  = 4'd3;
    localparam logic [OPT_WIDTH-1:0] OP_LD  = 4'd4;
    localparam logic [OPT_WIDTH-1:0] OP_LBU = 4'd5;
    localparam logic [OPT_WIDTH-1:0] OP_LHU = 4'd6;
    localparam logic [OPT_WIDTH-1:0] OP_LWU = 4'd7;
    localparam logic [OPT_WIDTH-1:0] OP_SB  = 4'd8;
    localparam logic [OPT_WIDTH-1:0] OP_SH  = 4'd9;
    localparam logic [OPT_WIDTH-1:0] OP_SW  = 4'd10;
    localparam logic [OPT_WIDTH-1:0] OP_SD  = 4'd11;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t                 state_q, state_d;
    logic [OPT_WIDTH-1:0]   opt_q;
    logic [CPU_WIDTH-1:0]   addr_q, wdata_q, rdata_q, rdata_d;
    logic                   capture;
    logic                   misalign_q, misalign_d;

    function automatic logic op_is_load(input logic [OPT_WIDTH-1:0] op);
        return (op >= OP_LB) && (op <= OP_LWU);
    endfunction

    function automatic logic op_is_store(input logic [OPT_WIDTH-1:0] op);
        return (op >= OP_SB) && (op <= OP_SD);
    endfunction

`ifdef YSYX_22050078_LSU_MISALIGN_TRAP_EN
    // Access size minus one; ANDed with the low address bits it flags misalignment.
    function automatic logic [2:0] op_size_m1(input logic [OPT_WIDTH-1:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return 3'd1;
            OP_LW, OP_LWU, OP_SW: return 3'd3;
            OP_LD, OP_SD:         return 3'd7;
            default:              return 3'd0;
        endcase
    endfunction

    logic in_misaligned;
    assign in_misaligned = (i_exu_res[2:0] & op_size_m1(i_lsopt)) != 3'd0;
    assign o_misalign    = misalign_q;
`endif

    logic [2:0]           lane;
    logic [5:0]           shamt;
    logic [CPU_WIDTH-1:0] rd_shifted;
    logic [CPU_WIDTH-1:0] load_ext;
    logic [7:0]           store_mask;
    logic                 is_store_q;

    assign lane       = addr_q[2:0];
    assign shamt      = {lane, 3'b000};
    assign is_store_q = op_is_store(opt_q);
    // Right shift brings the addressed lane to bit 0; bytes beyond the doubleword read as 0.
    assign rd_shifted = i_mem_rdata >> shamt;

    always_comb begin
        load_ext = rd_shifted;
        case (opt_q)
            OP_LB:   load_ext = {{56{rd_shifted[7]}},  rd_shifted[7:0]};
            OP_LH:   load_ext = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            OP_LW:   load_ext = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            OP_LBU:  load_ext = {56'd0, rd_shifted[7:0]};
            OP_LHU:  load_ext = {48'd0, rd_shifted[15:0]};
            OP_LWU:  load_ext = {32'd0, rd_shifted[31:0]};
            default: load_ext = rd_shifted;
        endcase
    end

    // 8-bit shift drops enables that would fall past the doubleword.
    always_comb begin
        store_mask = 8'h00;
        case (opt_q)
            OP_SB:   store_mask = 8'h01 << lane;
            OP_SH:   store_mask = 8'h03 << lane;
            OP_SW:   store_mask = 8'h0F << lane;
            OP_SD:   store_mask = 8'hFF;
            default: store_mask = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    capture = 1'b1;
                    if (!op_is_load(i_lsopt) && !op_is_store(i_lsopt)) begin
                        rdata_d = i_exu_res;
                        state_d = DONE;
                    end
`ifdef YSYX_22050078_LSU_MISALIGN_TRAP_EN
                    else if (in_misaligned) begin
                        rdata_d    = i_exu_res;
                        misalign_d = 1'b1;
                        state_d    = DONE;
                    end
`endif
                    else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (i_mem_gnt) begin
                    if (is_store_q) begin
                        rdata_d = '0;
                        state_d = DONE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (i_mem_rvalid) begin
                    rdata_d = load_ext;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    misalign_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            opt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            if (capture) begin
                opt_q   <= i_lsopt;
                addr_q  <= i_exu_res;
                wdata_q <= i_wdata;
            end
        end
    end

    assign o_ready     = (state_q == IDLE);
    assign o_valid     = (state_q == DONE);
    assign o_rdata     = rdata_q;
    assign o_mem_req   = (state_q == REQ);
    assign o_mem_addr  = {addr_q[CPU_WIDTH-1:3], 3'b000};
    assign o_mem_wen   = o_mem_req && is_store_q;
    assign o_mem_wmask = o_mem_wen ? store_mask : 8'h00;
    assign o_mem_wdata = o_mem_wen ? (wdata_q << shamt) : '0;

endmodule

// File: tb/tb_ysyx_22050078_lsu.sv
// tb/tb_ysyx_22050078_lsu.sv - table-driven and directed checks for ysyx_22050078_lsu
module tb_ysyx_22050078_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, i_ready, i_mem_gnt, i_mem_rvalid;
    logic [63:0] i_exu_res, i_wdata, i_mem_rdata;
    logic [3:0]  i_lsopt;
    logic        o_ready, o_valid, o_mem_req, o_mem_wen;
    logic [63:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic [7:0]  o_mem_wmask;
`ifdef YSYX_22050078_LSU_MISALIGN_TRAP_EN
    logic        o_misalign;
`endif

    ysyx_22050078_lsu dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_exu_res(i_exu_res), .i_wdata(i_wdata), .i_lsopt(i_lsopt),
        .o_valid(o_valid), .i_ready(i_ready), .o_rdata(o_rdata),
        .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_mem_addr(o_mem_addr),
        .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
`ifdef YSYX_22050078_LSU_MISALIGN_TRAP_EN
        , .o_misalign(o_misalign)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  opt;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] mrdata;
        logic [63:0] exp_rdata;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_mask;
    } vec_t;

    vec_t vecs[0:19];
    int   nvec = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] opt, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] mrdata, input logic [63:0] exp_rdata,
                           input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                           input logic [7:0] exp_mask);
        vecs[nvec] = '{opt, addr, wdata, mrdata, exp_rdata, exp_addr, exp_wdata, exp_mask};
        nvec++;
    endtask

    task automatic idle_inputs();
        i_valid = 0; i_mem_gnt = 0; i_mem_rvalid = 0;
        i_lsopt = 0; i_exu_res = 0; i_wdata = 0; i_mem_rdata = 0;
    endtask

    // Zero-wait transaction: gnt in the first REQ cycle, rvalid in the first RESP cycle.
    task automatic run_vec(input vec_t v, input int idx);
        logic is_mem, is_st;
        is_mem = (v.opt >= 4'd1) && (v.opt <= 4'd11);
        is_st  = (v.opt >= 4'd8) && (v.opt <= 4'd11);
        chk($sformatf("v%0d ready", idx), {63'd0, o_ready}, 64'd1);
        i_valid = 1; i_lsopt = v.opt; i_exu_res = v.addr; i_wdata = v.wdata;
        @(negedge i_clk);
        i_valid = 0; i_exu_res = 64'hDEAD_DEAD_DEAD_DEAD; i_wdata = 64'hBAD0_BAD0_BAD0_BAD0; i_lsopt = 4'd4;
        if (is_mem) begin
            chk($sformatf("v%0d req", idx), {63'd0, o_mem_req}, 64'd1);
            chk($sformatf("v%0d addr", idx), o_mem_addr, v.exp_addr);
            chk($sformatf("v%0d wen", idx), {63'd0, o_mem_wen}, {63'd0, is_st});
            chk($sformatf("v%0d mask", idx), {56'd0, o_mem_wmask}, {56'd0, v.exp_mask});
            if (is_st) chk($sformatf("v%0d wdata", idx), o_mem_wdata, v.exp_wdata);
            i_mem_gnt = 1;
            @(negedge i_clk);
            i_mem_gnt = 0;
            if (!is_st) begin
                chk($sformatf("v%0d req_drop", idx), {63'd0, o_mem_req}, 64'd0);
                i_mem_rvalid = 1; i_mem_rdata = v.mrdata;
                @(negedge i_clk);
                i_mem_rvalid = 0; i_mem_rdata = 64'hFFFF_0000_FFFF_0000;
            end
        end
        chk($sformatf("v%0d valid", idx), {63'd0, o_valid}, 64'd1);
        chk($sformatf("v%0d rdata", idx), o_rdata, v.exp_rdata);
        chk($sformatf("v%0d req_idle", idx), {63'd0, o_mem_req}, 64'd0);
`ifdef YSYX_22050078_LSU_MISALIGN_TRAP_EN
        chk($sformatf("v%0d misalign", idx), {63'd0, o_misalign}, 64'd0);
`endif
        @(negedge i_clk);
        chk($sformatf("v%0d back_idle", idx), {62'd0, o_valid, o_ready}, 64'd1);
    endtask

    initial begin
        idle_inputs();
        i_ready = 1;
        i_rst = 1;
        repeat (2) @(negedge i_clk);
        chk("rst_ready", {63'd0, o_ready}, 64'd1);
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_req", {63'd0, o_mem_req}, 64'd0);
        chk("rst_wen_mask", {55'd0, o_mem_wen, o_mem_wmask}, 64'd0);
        chk("rst_rdata", o_rdata, 64'd0);
        chk("rst_addr", o_mem_addr, 64'd0);
        chk("rst_wdata", o_mem_wdata, 64'd0);
        i_rst = 0;

        //       opt    addr                    wdata                   mrdata                  exp_rdata               exp_addr       exp_wdata               mask
        add_vec(4'd0,  64'h1234,               64'h0,                  64'h0,                  64'h1234,               64'h0,         64'h0,                  8'h00);
        add_vec(4'd1,  64'h8000_0003,          64'h0,                  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 64'h8000_0000, 64'h0,                8'h00);
        add_vec(4'd5,  64'h8000_0003,          64'h0,                  64'h0000_0000_8000_0000, 64'h80,                64'h8000_0000, 64'h0,                  8'h00);
        add_vec(4'd9,  64'h8000_0006,          64'hBEEF,               64'h0,                  64'h0,                  64'h8000_0000, 64'hBEEF_0000_0000_0000, 8'hC0);
        add_vec(4'd3,  64'h10,                 64'h0,                  64'h7FFF_FFFF_8000_0001, 64'hFFFF_FFFF_8000_0001, 64'h10,       64'h0,                  8'h00);
        add_vec(4'd7,  64'h14,                 64'h0,                  64'h8765_4321_0000_0000, 64'h8765_4321,         64'h10,        64'h0,                  8'h00);
        add_vec(4'd2,  64'h22,                 64'h0,                  64'h0000_0000_F00D_0000, 64'hFFFF_FFFF_FFFF_F00D, 64'h20,       64'h0,                  8'h00);
        add_vec(4'd6,  64'h22,                 64'h0,                  64'h0000_0000_F00D_0000, 64'hF00D,              64'h20,        64'h0,                  8'h00);
        add_vec(4'd4,  64'h100,                64'h0,                  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'h100,      64'h0,                  8'h00);
        add_vec(4'd8,  64'h105,                64'h1122_3344_5566_7788, 64'h0,                 64'h0,                  64'h100,       64'h6677_8800_0000_0000, 8'h20);
        add_vec(4'd10, 64'h104,                64'hDEAD_BEEF,          64'h0,                  64'h0,                  64'h100,       64'hDEAD_BEEF_0000_0000, 8'hF0);
        add_vec(4'd11, 64'h108,                64'hCAFE_F00D_1234_5678, 64'h0,                 64'h0,                  64'h108,       64'hCAFE_F00D_1234_5678, 8'hFF);
        add_vec(4'd13, 64'h55,                 64'h0,                  64'h0,                  64'h55,                 64'h0,         64'h0,                  8'h00);
        add_vec(4'd1,  64'h7,                  64'h0,                  64'h7F00_0000_0000_0000, 64'h7F,                64'h0,         64'h0,                  8'h00);
`ifndef YSYX_22050078_LSU_MISALIGN_TRAP_EN
        // Misaligned without trap: truncated to the doubleword.
        add_vec(4'd10, 64'h106,                64'hDEAD_BEEF,          64'h0,                  64'h0,                  64'h100,       64'hBEEF_0000_0000_0000, 8'hC0);
        add_vec(4'd3,  64'h6,                  64'h0,                  64'h1122_3344_5566_7788, 64'h1122,              64'h0,         64'h0,                  8'h00);
`endif

        @(negedge i_clk);
        for (int i = 0; i < nvec; i++) run_vec(vecs[i], i);

        // Store with gnt delayed: request must hold steady.
        i_valid = 1; i_lsopt = 4'd9; i_exu_res = 64'h8000_0006; i_wdata = 64'hBEEF;
        @(negedge i_clk);
        i_valid = 0; i_exu_res = 64'h0; i_wdata = 64'h1111;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold%0d req", k), {63'd0, o_mem_req}, 64'd1);
            chk($sformatf("hold%0d mask", k), {56'd0, o_mem_wmask}, 64'hC0);
            chk($sformatf("hold%0d wdata", k), o_mem_wdata, 64'hBEEF_0000_0000_0000);
            chk($sformatf("hold%0d addr", k), o_mem_addr, 64'h8000_0000);
            if (k < 2) @(negedge i_clk);
        end
        i_mem_gnt = 1;
        @(negedge i_clk);
        i_mem_gnt = 0;
        chk("hold_done_valid", {63'd0, o_valid}, 64'd1);
        chk("hold_done_rdata", o_rdata, 64'd0);
        chk("hold_done_req", {63'd0, o_mem_req}, 64'd0);
        @(negedge i_clk);

        // Load result held while write-back stalls; upstream changes ignored.
        i_ready = 0;
        i_valid = 1; i_lsopt = 4'd3; i_exu_res = 64'h10;
        @(negedge i_clk);
        i_valid = 0;
        i_mem_gnt = 1;
        @(negedge i_clk);
        i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 64'h7FFF_FFFF_8000_0001;
        @(negedge i_clk);
        i_mem_rvalid = 0; i_mem_rdata = 64'h0;
        i_valid = 1; i_lsopt = 4'd0; i_exu_res = 64'h9999;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d valid", k), {63'd0, o_valid}, 64'd1);
            chk($sformatf("stall%0d ready", k), {63'd0, o_ready}, 64'd0);
            chk($sformatf("stall%0d rdata", k), o_rdata, 64'hFFFF_FFFF_8000_0001);
            @(negedge i_clk);
        end
        i_valid = 0; i_ready = 1;
        @(negedge i_clk);
        chk("stall_release", {62'd0, o_valid, o_ready}, 64'd1);

        // Reset while waiting in RESP, then a late rvalid.
        i_valid = 1; i_lsopt = 4'd1; i_exu_res = 64'h40;
        @(negedge i_clk);
        i_valid = 0;
        i_mem_gnt = 1;
        @(negedge i_clk);
        i_mem_gnt = 0;
        chk("resp_wait_ready", {63'd0, o_ready}, 64'd0);
        i_rst = 1;
        @(negedge i_clk);
        i_rst = 0;
        chk("rst_resp_ready", {63'd0, o_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_resp_req", {63'd0, o_mem_req}, 64'd0);
        i_mem_rvalid = 1; i_mem_rdata = 64'hFF;
        @(negedge i_clk);
        i_mem_rvalid = 0;
        chk("late_rvalid_valid", {63'd0, o_valid}, 64'd0);
        chk("late_rvalid_ready", {63'd0, o_ready}, 64'd1);
        run_vec(vecs[0], 99);

`ifdef YSYX_22050078_LSU_MISALIGN_TRAP_EN
        i_valid = 1; i_lsopt = 4'd4; i_exu_res = 64'h8000_0004;
        @(negedge i_clk);
        i_valid = 0;
        chk("mis_valid", {63'd0, o_valid}, 64'd1);
        chk("mis_req", {63'd0, o_mem_req}, 64'd0);
        chk("mis_flag", {63'd0, o_misalign}, 64'd1);
        chk("mis_rdata", o_rdata, 64'h8000_0004);
        @(negedge i_clk);
        chk("mis_clear", {62'd0, o_misalign, o_valid}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
